nand_vector_sequencer: RTL and testbench

- Sequences exhaustive functional checking of a 2-input NAND datapath unit.
- Drives the unit's inputs through the four input combinations in a fixed order and waits a programmable settle time per vector.
- Samples the unit's output, compares it with the expected NAND value and accumulates per-vector pass/fail results.
- Sits between a control source (start/abort) and a NAND unit under check; it replaces hand-timed delay stimulus with a clocked, self-checking controller.

---
 rtl/nand_vector_sequencer.sv | 155 +++++++++++++++
 tb/tb_nand_vector_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nand_vector_sequencer.sv
// Walks a 2-input NAND unit through all four input vectors, holds each for SETTLE_CYCLES,
// samples its output and records per-vector mismatches; abort returns to IDLE keeping partial results.
module nand_vector_sequencer #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_w,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  // The SETTLE state spends one cycle per count down to zero, so load one less than the hold time.
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dut_a_q, dut_a_d;
  logic       dut_b_q, dut_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dut_a_d = dut_a_q;
    dut_b_d = dut_b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      IDLE: begin
        dut_a_d = 1'b0;
        dut_b_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          err_d   = 3'd0;
          fail_d  = 4'd0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          dut_a_d = 1'b0;
          dut_b_d = 1'b0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == 8'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          dut_a_d = 1'b0;
          dut_b_d = 1'b0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          if (dut_w != ~(dut_a_q & dut_b_q)) begin
            fail_d[idx_q] = 1'b1;
            err_d         = err_q + 3'd1;
          end
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            dut_a_d = idx_d[0];
            dut_b_d = idx_d[1];
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end else begin
            dut_a_d = 1'b0;
            dut_b_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Uses the count including this final sample.
            pass_d  = (err_d == 3'd0);
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        dut_a_d = 1'b0;
        dut_b_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      dut_a_q <= 1'b0;
      dut_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dut_a_q <= dut_a_d;
      dut_b_q <= dut_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_nand_vector_sequencer.sv
// Bench for nand_vector_sequencer: two instances (SETTLE_CYCLES 3 and 1) against a run-time based model.
module tb_nand_vector_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic w_rand = 1'b0;
  int   mode = 0;  // 0 true NAND, 1 stuck-at-1, 2 stuck-at-0, 3 random

  logic       a0, b0, busy0, done0, pass0, w0;
  logic [2:0] err0;
  logic [3:0] fail0;
  logic       a1, b1, busy1, done1, pass1, w1;
  logic [2:0] err1;
  logic [3:0] fail1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic wfn(int md, logic a, logic b, logic r);
    case (md)
      0:       return ~(a & b);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return r;
    endcase
  endfunction

  assign w0 = wfn(mode, a0, b0, w_rand);
  assign w1 = wfn(mode, a1, b1, w_rand);

  nand_vector_sequencer #(.SETTLE_CYCLES(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_w(w0),
    .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fail0)
  );

  nand_vector_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_w(w1),
    .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fail1)
  );

  // Model: ph 0 idle, 1 running (t = cycles since the start edge), 2 done cycle.
  typedef struct {
    int         ph;
    int         t;
    int         errs;
    logic [3:0] fails;
    logic       pass;
  } mdl_t;

  localparam mdl_t MRST = '{ph: 0, t: 0, errs: 0, fails: 4'b0000, pass: 1'b0};

  mdl_t m0 = MRST;
  mdl_t m1 = MRST;

  function automatic mdl_t step(mdl_t m, int s, logic st, logic ab, int md, logic r);
    mdl_t n = m;
    int   v;
    logic a, b, w;
    case (m.ph)
      0: if (st) begin
        n.ph = 1; n.t = 0; n.errs = 0; n.fails = 4'b0000; n.pass = 1'b0;
      end
      1: if (ab) begin
        n.ph = 0; n.pass = 1'b0;
      end else begin
        v = m.t / (s + 1);
        if (m.t % (s + 1) == s) begin
          a = v[0];
          b = v[1];
          w = wfn(md, a, b, r);
          if (w !== ~(a & b)) begin
            n.fails[v] = 1'b1;
            n.errs     = n.errs + 1;
          end
        end
        if (m.t == 4 * (s + 1) - 1) begin
          n.ph   = 2;
          n.pass = (n.errs == 0);
        end else begin
          n.t = m.t + 1;
        end
      end
      default: n.ph = 0;
    endcase
    return n;
  endfunction

  function automatic logic [11:0] outs(mdl_t m, int s);
    int   v = m.t / (s + 1);
    logic a = (m.ph == 1) ? v[0] : 1'b0;
    logic b = (m.ph == 1) ? v[1] : 1'b0;
    return {a, b, (m.ph == 1), (m.ph == 2), m.pass, 3'(m.errs), m.fails};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= MRST;
      m1 <= MRST;
    end else begin
      m0 <= step(m0, 3, start, abort, mode, w_rand);
      m1 <= step(m1, 1, start, abort, mode, w_rand);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("cycle_s3", {20'd0, a0, b0, busy0, done0, pass0, err0, fail0}, {20'd0, outs(m0, 3)});
    chk("cycle_s1", {20'd0, a1, b1, busy1, done1, pass1, err1, fail1}, {20'd0, outs(m1, 1)});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_seq(input int md, input bit spam,
                         output int d0_at, output int d1_at, output int d0_cnt);
    mode  = md;
    start = 1'b1;
    tick();
    start  = 1'b0;
    d0_at  = -1;
    d1_at  = -1;
    d0_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (done0) begin
        if (d0_at < 0) d0_at = n;
        d0_cnt++;
      end
      if (done1 && d1_at < 0) d1_at = n;
      start = spam && (n <= 15) && (n % 3 == 0);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    int d0_at, d1_at, d0_cnt, ndone;

    repeat (2) tick();
    chk("reset_s3", {20'd0, a0, b0, busy0, done0, pass0, err0, fail0}, 32'd0);
    chk("reset_s1", {20'd0, a1, b1, busy1, done1, pass1, err1, fail1}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Good NAND unit
    run_seq(0, 1'b0, d0_at, d1_at, d0_cnt);
    chk("good_done_at_s3", d0_at, 16);
    chk("good_done_at_s1", d1_at, 8);
    chk("good_res_s3", {pass0, err0, fail0}, {1'b1, 3'd0, 4'b0000});
    chk("good_res_s1", {pass1, err1, fail1}, {1'b1, 3'd0, 4'b0000});

    // Output stuck at 1: only vector 3 fails
    run_seq(1, 1'b0, d0_at, d1_at, d0_cnt);
    chk("st1_done_at", d0_at, 16);
    chk("st1_res_s3", {pass0, err0, fail0}, {1'b0, 3'd1, 4'b1000});

    // Output stuck at 0: vectors 0..2 fail
    run_seq(2, 1'b0, d0_at, d1_at, d0_cnt);
    chk("st0_res_s3", {pass0, err0, fail0}, {1'b0, 3'd3, 4'b0111});
    chk("st0_res_s1", {pass1, err1, fail1}, {1'b0, 3'd3, 4'b0111});

    // Start spammed while busy
    run_seq(0, 1'b1, d0_at, d1_at, d0_cnt);
    chk("spam_done_cnt", d0_cnt, 1);
    chk("spam_done_at", d0_at, 16);

    // Abort in the settle window of vector 2
    mode  = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("pre_abort_vec", {a0, b0, busy0}, {1'b0, 1'b1, 1'b1});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_outs", {a0, b0, busy0, done0, pass0, err0, fail0},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000});
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      if (done0) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);
    run_seq(0, 1'b0, d0_at, d1_at, d0_cnt);
    chk("after_abort_done_at", d0_at, 16);
    chk("after_abort_res", {pass0, err0, fail0}, {1'b1, 3'd0, 4'b0000});

    // Asynchronous reset between edges, mid-run
    mode  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s3", {20'd0, a0, b0, busy0, done0, pass0, err0, fail0}, 32'd0);
    chk("arst_s1", {20'd0, a1, b1, busy1, done1, pass1, err1, fail1}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Random output, start and abort traffic
    mode = 3;
    for (int n = 0; n < 800; n++) begin
      w_rand = 1'($urandom);
      start  = ($urandom_range(3) == 0);
      abort  = ($urandom_range(11) == 0);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
